// File: rtl/neuro_decay_pkg.sv
// Shared mode/state encodings and Izhikevich-style constants for the potential decay unit.
package neuro_decay_pkg;

  typedef enum logic [2:0] {
    LIF0  = 3'd0,
    LIF2  = 3'd1,
    LIF4  = 3'd2,
    LIF8  = 3'd3,
    LIF24 = 3'd4,
    IZHI  = 3'd5,
    QUAD  = 3'd6,
    IDLE  = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CALC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  localparam int IZHI_MUL   = 5;
  localparam int IZHI_SHIFT = 3;

endpackage

// File: rtl/decay_datapath.sv
// Decay arithmetic (shifts, square, saturation) for one potential; result registered 1 cycle after v/mode.
// No backpressure: a new result is produced every cycle.
module decay_datapath
  import neuro_decay_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] v,
  input  mode_e                    mode,
  output logic signed [DATA_W-1:0] result
);

  // Headroom above the full square so the IZHI subtraction can never wrap.
  localparam int WW = 2 * DATA_W + 4;
  localparam logic signed [WW-1:0] MAX_W = (WW'(1) <<< (DATA_W - 1)) - WW'(1);
  localparam logic signed [WW-1:0] MIN_W = -MAX_W - WW'(1);

  logic signed [WW-1:0]     v_w;
  logic signed [WW-1:0]     sq;
  logic signed [WW-1:0]     quad_w;
  logic signed [WW-1:0]     izhi_w;
  logic signed [DATA_W-1:0] nxt;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [WW-1:0] x);
    if (x > MAX_W) begin
      return MAX_W[DATA_W-1:0];
    end else if (x < MIN_W) begin
      return MIN_W[DATA_W-1:0];
    end else begin
      return x[DATA_W-1:0];
    end
  endfunction

  always_comb begin
    v_w    = WW'(v);
    sq     = v_w * v_w;
    quad_w = sq >>> FRAC_W;
    izhi_w = (sq >>> (FRAC_W + IZHI_SHIFT)) - (v_w * WW'(IZHI_MUL));
    nxt    = v;
    case (mode)
      LIF0:    nxt = v;
      LIF2:    nxt = v >>> 1;
      LIF4:    nxt = v >>> 2;
      LIF8:    nxt = v >>> 3;
      LIF24:   nxt = (v >>> 1) + (v >>> 2);
      QUAD:    nxt = sat(quad_w);
      IZHI:    nxt = sat(izhi_w);
      default: nxt = v;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      result <= '0;
    end else begin
      result <= nxt;
    end
  end

endmodule

// File: rtl/multi_channel_potential_decay.sv
// Register file of NUM_CH potentials swept through one shared decay datapath, 3 cycles per channel.
// No backpressure: host writes always land and override an in-flight decay of the same channel.
module multi_channel_potential_decay
  import neuro_decay_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 16,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic signed [DATA_W-1:0] wr_potential,
  input  logic [2:0]               wr_mode,
  input  logic                     time_step,
  input  logic [CH_W-1:0]          rd_ch,
  output logic signed [DATA_W-1:0] rd_potential,
  output logic [2:0]               rd_mode,
  output logic                     busy,
  output logic                     sweep_done,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W-1:0] out_potential,
  output logic                     err_overrun
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic signed [DATA_W-1:0] pot_mem  [NUM_CH];
  logic [2:0]               mode_mem [NUM_CH];

  state_e                   state;
  logic [CH_W-1:0]          ch;
  logic                     prev_ts;
  logic                     start;
  logic                     drop;
  logic                     hit;
  logic                     commit;
  logic signed [DATA_W-1:0] v_in;
  mode_e                    mode_in;
  logic signed [DATA_W-1:0] dp_result;

  assign start  = time_step & ~prev_ts;
  // A host write to the channel in flight makes the host value final for this sweep.
  assign hit    = wr_en && (wr_ch == ch) && (state != S_IDLE);
  assign commit = (state == S_WRITE) && !drop && !hit && (mode_in != IDLE);

  decay_datapath #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .v      (v_in),
    .mode   (mode_in),
    .result (dp_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pot_mem[i]  <= '0;
        mode_mem[i] <= IDLE;
      end
      rd_potential <= '0;
      rd_mode      <= '0;
    end else begin
      if (commit) begin
        pot_mem[ch] <= dp_result;
      end
      if (wr_en) begin
        pot_mem[wr_ch]  <= wr_potential;
        mode_mem[wr_ch] <= wr_mode;
      end
      rd_potential <= pot_mem[rd_ch];
      rd_mode      <= mode_mem[rd_ch];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      ch            <= '0;
      prev_ts       <= 1'b0;
      drop          <= 1'b0;
      v_in          <= '0;
      mode_in       <= IDLE;
      busy          <= 1'b0;
      sweep_done    <= 1'b0;
      out_valid     <= 1'b0;
      out_ch        <= '0;
      out_potential <= '0;
      err_overrun   <= 1'b0;
    end else begin
      prev_ts    <= time_step;
      sweep_done <= 1'b0;
      out_valid  <= 1'b0;
      if (start && (state != S_IDLE)) begin
        err_overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            ch    <= '0;
            busy  <= 1'b1;
            state <= S_READ;
          end
        end
        S_READ: begin
          v_in    <= pot_mem[ch];
          mode_in <= mode_e'(mode_mem[ch]);
          drop    <= hit;
          state   <= S_CALC;
        end
        S_CALC: begin
          drop  <= drop | hit;
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (commit) begin
            out_valid     <= 1'b1;
            out_ch        <= ch;
            out_potential <= dp_result;
          end
          drop <= 1'b0;
          if (ch == LAST_CH) begin
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            state      <= S_IDLE;
          end else begin
            ch    <= ch + 1'b1;
            state <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
